ped_request_unit: RTL and testbench
===================================

Name: ped_request_unit

Overview:
- Upstream conditioning stage for the intersection traffic controller.
- Takes the raw pedestrian call button and synchronises and debounces it.
- Converts presses into a held walk request that stays asserted until the controller shows the walk signal green on `lightw`.
- Flags requests left waiting too long as urgent; counts presses for diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before `btn_clean` changes; legal range 1..255.
- MAX_WAIT, 12: cycles a request may stay PENDING before `walk_urgent` asserts; legal range 1..255.
- CNT_W, 3: width of `press_count`.

Ports:
- `CLK` input 1: slow system clock, the same divided clock that drives the controller; all state updates on posedge.
- `RST` input 1: asynchronous, active-high reset.
- `btn` input 1: raw pedestrian button, asynchronous, bouncy.
- `lightw` input 2: walk lamp state from the controller; 2'b01 = walk green, 2'b10 = walk red, 2'b00 = off.
- `walk_req` output 1: held walk request to the controller.
- `walk_urgent` output 1: request has waited MAX_WAIT cycles or more.
- `press_count` output CNT_W: accepted press events since the last service, saturating.
- `btn_clean` output 1: debounced button level.

Behaviour:
- Clocking and reset:
  - All registers update on posedge `CLK` or asynchronously on `RST`=1.
  - Outputs are registered, so they are stable for a consumer sampling on negedge.
- Reset values (held while `RST`=1, clears any request mid-operation):
  - sync flops = 0, `btn_clean` = 0, debounce counter = 0, wait counter = 0.
  - `press_count` = 0, `walk_req` = 0, `walk_urgent` = 0, state = IDLE.
- Synchroniser: two flops, btn -> s1 -> s2; only s2 is used downstream.
- Debounce:
  - While s2 == `btn_clean`, the counter holds at 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and s2 still differs, `btn_clean` <= s2 and the counter <= 0.
  - Any cycle where s2 == `btn_clean` resets the counter to 0, so a glitch shorter than DEBOUNCE_CYCLES never propagates.
- Latency: `btn` held high from edge 1 gives `btn_clean` high after edge 2+DEBOUNCE_CYCLES.
- press event: one-cycle pulse on the cycle `btn_clean` goes 0 -> 1 (registered edge detect); falling edges are not events.
- FSM states: IDLE, PENDING, SERVING.
  - IDLE:
    - press with `lightw` != 01 -> PENDING; `walk_req` <= 1; wait counter <= 0; `press_count` += 1.
    - press with `lightw` == 01 -> stay IDLE, press ignored (walk already green).
  - PENDING:
    - `walk_req` = 1; wait counter increments, saturating at MAX_WAIT.
    - `walk_urgent` <= 1 once the wait counter == MAX_WAIT-1 is incremented; sticky until service.
    - Each further press increments `press_count`.
    - `lightw` == 01 -> SERVING; `walk_req` <= 0; `walk_urgent` <= 0; `press_count` <= 0; wait counter <= 0.
    - A press in the same cycle as `lightw` == 01 is discarded.
  - SERVING:
    - All presses ignored; outputs stay 0.
    - `lightw` != 01 -> IDLE (this covers the flashing 00/10 sequence after walk green ends).
    - A press on the exit cycle is ignored; the next press re-arms.
- `press_count` saturates at 2^CNT_W-1 and never wraps.
- `lightw` == 2'b11 is illegal and is treated as != 01.
- `walk_req` latency: a press pulse at edge n gives `walk_req` = 1 after edge n+1.

Test Plan:
1. Reset and clean press:
   - Stimulus: `RST` pulse; `lightw`=10; `btn` high from edge 1 (DEBOUNCE_CYCLES=4).
   - Response: all outputs 0 during reset; `btn_clean` rises after edge 6; `walk_req`=1 after edge 7; `press_count`=1.
2. Bounce rejection:
   - Stimulus: `btn` toggles 1,0,1,0 every cycle for 8 cycles, then stays 0.
   - Response: `btn_clean`, `walk_req` and `press_count` stay 0.
3. Urgency and service:
   - Stimulus: request pending with `lightw`=10 (MAX_WAIT=12).
   - Response: `walk_urgent`=1 exactly 12 cycles after `walk_req` rose.
   - Stimulus: drive `lightw`=01.
   - Response: next edge `walk_req`=0, `walk_urgent`=0, `press_count`=0, state SERVING.
4. Saturation and ignore rules:
   - Stimulus: 9 clean presses while PENDING (CNT_W=3).
   - Response: `press_count` holds 7.
   - Stimulus: presses in SERVING or in IDLE with `lightw`=01.
   - Response: `walk_req` stays 0.
5. Simultaneous events:
   - Stimulus: press pulse on the same edge `lightw` becomes 01 while PENDING.
   - Response: SERVING, `press_count`=0.
   - Stimulus: `lightw` -> 00, then a new press.
   - Response: `walk_req`=1, `press_count`=1.
6. Reset mid-operation:
   - Stimulus: `RST`=1 asynchronously between edges while PENDING with `walk_urgent`=1.
   - Response: `walk_req`, `walk_urgent` and `press_count` drop to 0 immediately without a clock edge; IDLE after release.

Source files
------------

// File: rtl/ped_request_unit.sv
// Pedestrian request conditioning for the intersection controller.
// Synchronises and debounces the raw call button. It then holds a walk
// request until the controller shows walk green, flags long waits as
// urgent, and counts accepted presses.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no request outstanding; a press arms a request
// ST_PENDING | walk_req held; wait timer running; presses counted
// ST_SERVING | walk green shown; presses ignored until the lamp leaves green
module ped_request_unit #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_WAIT        = 12,
   parameter int CNT_W           = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             btn,
   input  logic [1:0]       lightw,
   output logic             walk_req,
   output logic             walk_urgent,
   output logic [CNT_W-1:0] press_count,
   output logic             btn_clean
);

   localparam logic [7:0]       DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);
   localparam logic [7:0]       WAIT_SAT  = 8'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_SERVING = 2'd2
   } state_t;

   logic             s1, s2;
   logic [7:0]       deb_cnt;
   logic             clean_d;
   logic             press;
   logic             walk_green;

   state_t           state, state_n;
   logic [7:0]       wait_cnt, wait_cnt_n;
   logic             walk_req_n, walk_urgent_n;
   logic [CNT_W-1:0] press_count_n;
   logic [CNT_W-1:0] press_count_inc;

   // two-flop synchroniser for the asynchronous button
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

   // debounce: btn_clean follows s2 only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         deb_cnt   <= 8'd0;
         btn_clean <= 1'b0;
      end else if (s2 == btn_clean) begin
         deb_cnt <= 8'd0;
      end else if (deb_cnt == DEB_LAST) begin
         btn_clean <= s2;
         deb_cnt   <= 8'd0;
      end else begin
         deb_cnt <= deb_cnt + 8'd1;
      end
   end

   // delayed copy of btn_clean for rising-edge detection
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) clean_d <= 1'b0;
      else     clean_d <= btn_clean;
   end

   assign press           = btn_clean & ~clean_d;
   assign walk_green      = (lightw == 2'b01);
   assign press_count_inc = (press_count == CNT_MAX) ? press_count : press_count + 1'b1;

   // request state and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= ST_IDLE;
         wait_cnt    <= 8'd0;
         walk_req    <= 1'b0;
         walk_urgent <= 1'b0;
         press_count <= '0;
      end else begin
         state       <= state_n;
         wait_cnt    <= wait_cnt_n;
         walk_req    <= walk_req_n;
         walk_urgent <= walk_urgent_n;
         press_count <= press_count_n;
      end
   end

   // next-state and next-output decode
   always_comb begin
      state_n       = state;
      wait_cnt_n    = wait_cnt;
      walk_req_n    = walk_req;
      walk_urgent_n = walk_urgent;
      press_count_n = press_count;
      case (state)
         ST_IDLE: begin
            if (press && !walk_green) begin
               state_n       = ST_PENDING;
               walk_req_n    = 1'b1;
               wait_cnt_n    = 8'd0;
               press_count_n = press_count_inc;
            end
         end
         ST_PENDING: begin
            if (walk_green) begin
               // service wins over a coincident press
               state_n       = ST_SERVING;
               walk_req_n    = 1'b0;
               walk_urgent_n = 1'b0;
               press_count_n = '0;
               wait_cnt_n    = 8'd0;
            end else begin
               walk_req_n = 1'b1;
               if (wait_cnt != WAIT_SAT) wait_cnt_n = wait_cnt + 8'd1;
               if (wait_cnt == WAIT_LAST) walk_urgent_n = 1'b1;
               if (press) press_count_n = press_count_inc;
            end
         end
         ST_SERVING: begin
            walk_req_n    = 1'b0;
            walk_urgent_n = 1'b0;
            if (!walk_green) state_n = ST_IDLE;
         end
         default: begin
            state_n       = ST_IDLE;
            walk_req_n    = 1'b0;
            walk_urgent_n = 1'b0;
            press_count_n = '0;
            wait_cnt_n    = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_ped_request_unit.sv
// Bench for ped_request_unit: directed scenarios followed by random button
// and lamp activity, all checked against a behavioural request model.
module tb_ped_request_unit;

   localparam int DEB     = 4;
   localparam int MAXW    = 12;
   localparam int CW      = 3;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RST;
   logic          btn;
   logic [1:0]    lightw;
   logic          walk_req;
   logic          walk_urgent;
   logic [CW-1:0] press_count;
   logic          btn_clean;

   int vectors     = 0;
   int miscompares = 0;

   // behavioural model: phase 0 = idle, 1 = request waiting, 2 = walk being served
   int m_s1, m_s2, m_clean, m_clean_d, m_run;
   int m_phase, m_age, m_presses;

   ped_request_unit #(
      .DEBOUNCE_CYCLES(DEB),
      .MAX_WAIT(MAXW),
      .CNT_W(CW)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .btn(btn),
      .lightw(lightw),
      .walk_req(walk_req),
      .walk_urgent(walk_urgent),
      .press_count(press_count),
      .btn_clean(btn_clean)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_clean_d = 0; m_run = 0;
      m_phase = 0; m_age = 0; m_presses = 0;
   endfunction

   function automatic void model_edge(input int b, input logic [1:0] lw);
      int pr;
      int green;
      int n_clean;
      int n_run;
      pr    = (m_clean == 1 && m_clean_d == 0) ? 1 : 0;
      green = (lw == 2'b01) ? 1 : 0;
      // button level is accepted once it has disagreed for DEB edges in a row
      n_clean = m_clean;
      n_run   = 0;
      if (m_s2 != m_clean) begin
         if (m_run + 1 >= DEB) n_clean = m_s2;
         else                  n_run   = m_run + 1;
      end
      m_clean_d = m_clean;
      m_clean   = n_clean;
      m_run     = n_run;
      m_s2      = m_s1;
      m_s1      = b;
      case (m_phase)
         0: if (pr == 1 && green == 0) begin
               m_phase = 1; m_age = 0; m_presses = 1;
            end
         1: if (green == 1) begin
               m_phase = 2; m_age = 0; m_presses = 0;
            end else begin
               m_age++;
               if (pr == 1) m_presses++;
            end
         default: if (green == 0) m_phase = 0;
      endcase
   endfunction

   task automatic check_all();
      int exp_cnt;
      exp_cnt = (m_phase == 1) ? ((m_presses > CNT_MAX) ? CNT_MAX : m_presses) : 0;
      check("btn_clean",   btn_clean,   m_clean);
      check("walk_req",    walk_req,    (m_phase == 1) ? 1 : 0);
      check("walk_urgent", walk_urgent, (m_phase == 1 && m_age >= MAXW) ? 1 : 0);
      check("press_count", press_count, exp_cnt);
   endtask

   task automatic step();
      int b;
      logic [1:0] lw;
      b  = int'(btn);
      lw = lightw;
      @(posedge CLK);
      #1;
      model_edge(b, lw);
      check_all();
   endtask

   task automatic press_btn(input int hold, input int gap);
      btn = 1'b1;
      repeat (hold) step();
      btn = 1'b0;
      repeat (gap) step();
   endtask

   // called #1 after an edge: asserts reset mid-cycle and releases it after the next edge
   task automatic async_reset();
      #3;
      RST = 1'b1;
      #1;
      model_reset();
      check("rst_async_req",    walk_req,    0);
      check("rst_async_urgent", walk_urgent, 0);
      check("rst_async_count",  press_count, 0);
      check_all();
      @(posedge CLK);
      #1;
      check_all();
      RST = 1'b0;
   endtask

   initial begin
      int k;
      int found;
      RST    = 1'b1;
      btn    = 1'b0;
      lightw = 2'b10;
      model_reset();
      #2;
      check_all();
      @(posedge CLK);
      #2;
      RST = 1'b0;

      // reset and clean press: btn high from edge 1
      btn = 1'b1;
      repeat (5) step();
      check("lat_clean_early", btn_clean, 0);
      step();
      check("lat_clean", btn_clean, 1);
      step();
      check("lat_req", walk_req, 1);
      check("lat_count", press_count, 1);

      // urgency after MAX_WAIT cycles pending
      k = 0;
      while (walk_urgent !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      check("urgent_delay", k, MAXW);

      // service
      lightw = 2'b01;
      step();
      check("svc_req", walk_req, 0);
      check("svc_urgent", walk_urgent, 0);
      check("svc_count", press_count, 0);
      btn = 1'b0;
      repeat (8) step();
      lightw = 2'b10;
      step();

      // bounce rejection
      for (int i = 0; i < 8; i++) begin
         btn = (i % 2 == 0) ? 1'b1 : 1'b0;
         step();
      end
      btn = 1'b0;
      repeat (6) step();
      check("bounce_clean", btn_clean, 0);
      check("bounce_req", walk_req, 0);
      check("bounce_count", press_count, 0);

      // saturation with nine presses
      repeat (9) press_btn(7, 7);
      check("sat_count", press_count, CNT_MAX);

      // presses ignored while serving and in idle with walk green
      lightw = 2'b01;
      step();
      press_btn(7, 7);
      check("serve_ignore", walk_req, 0);
      lightw = 2'b00;
      step();
      lightw = 2'b01;
      step();
      press_btn(7, 7);
      check("idle_green_ignore", walk_req, 0);

      // press coincident with walk green while pending
      lightw = 2'b10;
      press_btn(7, 7);
      check("pend_again", walk_req, 1);
      btn   = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         step();
         if (m_clean == 1 && m_clean_d == 0) found = 1;
      end
      check("press_found", found, 1);
      lightw = 2'b01;
      step();
      check("simul_count", press_count, 0);
      check("simul_req", walk_req, 0);
      btn = 1'b0;
      repeat (7) step();
      lightw = 2'b00;
      step();
      press_btn(7, 3);
      check("rearm_req", walk_req, 1);
      check("rearm_count", press_count, 1);

      // asynchronous reset while urgent
      lightw = 2'b10;
      repeat (14) step();
      check("pre_rst_urgent", walk_urgent, 1);
      async_reset();
      step();
      check("post_rst_req", walk_req, 0);

      // random activity
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) btn = ~btn;
         if ($urandom_range(0, 19) == 0) lightw = 2'($urandom_range(0, 3));
         step();
         if ($urandom_range(0, 299) == 0) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
